// File: rtl/array_memory_pkg.sv
// array_memory_pkg: opcodes, FSM states and sizing helpers for the array memory engine
package array_memory_pkg;
  typedef enum logic [4:0] {
    A_CLEAR   = 5'd1,
    A_WRITE   = 5'd2,
    A_READ    = 5'd3,
    A_SIZE    = 5'd4,
    A_INC     = 5'd5,
    A_DEC     = 5'd6,
    A_INDEX   = 5'd7,
    A_LESS    = 5'd8,
    A_GREATER = 5'd9,
    A_INSERT  = 5'd10,
    A_DELETE  = 5'd11,
    A_PUSH    = 5'd14,
    A_POP     = 5'd15,
    A_RESIZE  = 5'd17
  } action_t;
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SHIFT_UP, S_SHIFT_DOWN, S_RESP} state_t;
  function automatic int depth(input int index_bits);
    return 1 << index_bits;
  endfunction
  function automatic int arrays(input int array_bits);
    return 1 << array_bits;
  endfunction
endpackage

// File: rtl/array_memory_store.sv
// array_memory_store: flat {array,index} word storage plus the per-array size table
module array_memory_store import array_memory_pkg::*; #(
  parameter int ARRAY_BITS = 4,
  parameter int INDEX_BITS = 3,
  parameter int DATA_BITS  = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             we_i,
  input  logic [ARRAY_BITS+INDEX_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0]             wdata_i,
  input  logic [ARRAY_BITS+INDEX_BITS-1:0] raddr0_i,
  input  logic [ARRAY_BITS+INDEX_BITS-1:0] raddr1_i,
  output logic [DATA_BITS-1:0]             rdata0_o,
  output logic [DATA_BITS-1:0]             rdata1_o,
  input  logic                             clr_i,
  input  logic                             sz_we_i,
  input  logic [ARRAY_BITS-1:0]            sz_addr_i,
  input  logic [INDEX_BITS:0]              sz_wdata_i,
  output logic [INDEX_BITS:0]              sz_rdata_o
);
  localparam int N = arrays(ARRAY_BITS);
  logic [DATA_BITS-1:0] mem_q [N*depth(INDEX_BITS)];
  logic [INDEX_BITS:0]  size_q [N];
  assign rdata0_o   = mem_q[raddr0_i];
  assign rdata1_o   = mem_q[raddr1_i];
  assign sz_rdata_o = size_q[sz_addr_i];
  // Word array: single write port, contents survive reset
  always_ff @(posedge clock)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  // Size table: async reset, bulk clear, otherwise one entry per cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int k = 0; k < N; k++) size_q[k] <= '0;
    else if (clr_i) for (int k = 0; k < N; k++) size_q[k] <= '0;
    else if (sz_we_i) size_q[sz_addr_i] <= sz_wdata_i;
endmodule

// File: rtl/array_memory_engine.sv
// array_memory_engine: request/response engine running array ops over the store, one element per cycle
module array_memory_engine import array_memory_pkg::*; #(
  parameter int ARRAY_BITS = 4,
  parameter int INDEX_BITS = 3,
  parameter int DATA_BITS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_action,
  input  logic [ARRAY_BITS-1:0] req_array,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [DATA_BITS-1:0]  req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_BITS-1:0]  rsp_data,
  output logic                  rsp_error
);
  localparam int SW = INDEX_BITS + 1;
  localparam logic [SW-1:0] FULL = SW'(depth(INDEX_BITS));
  if (DATA_BITS < SW) begin : g_width_check
    $error("DATA_BITS must be at least INDEX_BITS+1");
  end
  state_t state_q, idle_nxt;
  logic [4:0] act_q;
  logic [ARRAY_BITS-1:0] arr_q, sz_addr;
  logic [INDEX_BITS-1:0] idx_q, cnt_q, s_lo, s_m1, widx, ridx0;
  logic [DATA_BITS-1:0] data_q, rsp_data_q, rd0, rd1, idle_data, wdata, st_wdata;
  logic [SW-1:0] s_q, s, sz_wdata, st_sz_wdata;
  logic rsp_valid_q, rsp_error_q, err, we, sz_we, clr, go;
  logic i_ge_s, ins_app, del_last, scan_last, up_last, down_last, hit;
  logic st_we, st_sz_we, st_clr;
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign go        = req_ready && req_valid && !err;
  assign s_lo      = s[INDEX_BITS-1:0];
  assign s_m1      = s_lo - 1'b1;
  assign i_ge_s    = {1'b0, req_index} >= s;
  assign ins_app   = {1'b0, req_index} == s;
  assign del_last  = {1'b0, req_index} == s - 1'b1;
  assign scan_last = {1'b0, cnt_q} == s_q - 1'b1;
  assign up_last   = cnt_q == idx_q;
  assign down_last = {1'b0, cnt_q} == s_q - SW'(2);
  assign hit = act_q == A_INDEX ? rsp_data_q == '0 && rd0 == data_q : act_q == A_LESS ? rd0 < data_q : rd0 > data_q;
  // While idle the store is driven by the request; otherwise by the latched shift/scan cursor
  assign sz_addr     = req_ready ? req_array : arr_q;
  assign ridx0       = req_ready ? s_m1 : state_q == S_SHIFT_UP ? cnt_q - 1'b1 : state_q == S_SHIFT_DOWN ? cnt_q + 1'b1 : cnt_q;
  assign st_we       = req_ready ? go && we : state_q == S_SHIFT_UP || state_q == S_SHIFT_DOWN;
  assign st_wdata    = req_ready ? wdata : state_q == S_SHIFT_UP && up_last ? data_q : rd0;
  assign st_sz_we    = req_ready ? go && sz_we : (state_q == S_SHIFT_UP && up_last) || (state_q == S_SHIFT_DOWN && down_last);
  assign st_sz_wdata = req_ready ? sz_wdata : state_q == S_SHIFT_UP ? s_q + 1'b1 : s_q - 1'b1;
  assign st_clr      = go && clr;
  array_memory_store #(.ARRAY_BITS(ARRAY_BITS), .INDEX_BITS(INDEX_BITS), .DATA_BITS(DATA_BITS)) u_store (
    .clock(clock), .reset(reset),
    .we_i(st_we), .waddr_i(req_ready ? {req_array, widx} : {arr_q, cnt_q}), .wdata_i(st_wdata),
    .raddr0_i({sz_addr, ridx0}), .raddr1_i({req_array, req_index}),
    .rdata0_o(rd0), .rdata1_o(rd1),
    .clr_i(st_clr), .sz_we_i(st_sz_we), .sz_addr_i(sz_addr), .sz_wdata_i(st_sz_wdata), .sz_rdata_o(s)
  );
  // Decode the offered request: range check, accept-edge store updates, next state and response word
  always_comb begin
    err = 1'b0; idle_nxt = S_RESP; idle_data = '0; we = 1'b0; widx = req_index; wdata = req_data;
    sz_we = 1'b0; sz_wdata = s + 1'b1; clr = 1'b0;
    case (req_action)
      A_CLEAR:  clr = 1'b1;
      A_WRITE:  begin we = 1'b1; sz_we = i_ge_s; sz_wdata = {1'b0, req_index} + 1'b1; idle_data = req_data; end
      A_READ:   begin err = i_ge_s; idle_data = rd1; end
      A_SIZE:   idle_data = DATA_BITS'(s);
      A_INC:    begin err = s == FULL; sz_we = 1'b1; end
      A_DEC:    begin err = s == '0; sz_we = 1'b1; sz_wdata = s - 1'b1; end
      A_INDEX, A_LESS, A_GREATER: idle_nxt = s == '0 ? S_RESP : S_SCAN;
      A_INSERT: begin
        err = s == FULL || {1'b0, req_index} > s; we = 1'b1; widx = s_lo; wdata = ins_app ? req_data : rd0;
        sz_we = ins_app; idle_nxt = ins_app ? S_RESP : S_SHIFT_UP; idle_data = req_data;
      end
      A_DELETE: begin err = i_ge_s; sz_we = del_last; sz_wdata = s - 1'b1; idle_nxt = del_last ? S_RESP : S_SHIFT_DOWN; idle_data = rd1; end
      A_PUSH:   begin err = s == FULL; we = 1'b1; widx = s_lo; sz_we = 1'b1; idle_data = req_data; end
      A_POP:    begin err = s == '0; sz_we = 1'b1; sz_wdata = s - 1'b1; idle_data = rd0; end
      A_RESIZE: begin err = req_data > DATA_BITS'(FULL); sz_we = 1'b1; sz_wdata = req_data[SW-1:0]; end
      default:  err = 1'b1;
    endcase
    if (err) begin idle_nxt = S_RESP; idle_data = '0; end
  end
  // Engine FSM: latches the request, walks the scan/shift cursor and holds the response until taken
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= S_IDLE; rsp_valid_q <= 1'b0; rsp_data_q <= '0; rsp_error_q <= 1'b0;
      act_q <= '0; arr_q <= '0; idx_q <= '0; data_q <= '0; s_q <= '0; cnt_q <= '0;
    end else case (state_q)
      S_IDLE: if (req_valid) begin
        state_q <= idle_nxt; rsp_valid_q <= idle_nxt == S_RESP; rsp_data_q <= idle_data; rsp_error_q <= err;
        act_q <= req_action; arr_q <= req_array; idx_q <= req_index; data_q <= req_data; s_q <= s;
        cnt_q <= req_action == A_INSERT ? s_m1 : req_action == A_DELETE ? req_index : '0;
      end
      S_SCAN: begin
        if (hit) rsp_data_q <= act_q == A_INDEX ? DATA_BITS'(cnt_q) + 1'b1 : rsp_data_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
        if (scan_last) begin state_q <= S_RESP; rsp_valid_q <= 1'b1; end
      end
      S_SHIFT_UP: begin
        cnt_q <= cnt_q - 1'b1;
        if (up_last) begin state_q <= S_RESP; rsp_valid_q <= 1'b1; end
      end
      S_SHIFT_DOWN: begin
        cnt_q <= cnt_q + 1'b1;
        if (down_last) begin state_q <= S_RESP; rsp_valid_q <= 1'b1; end
      end
      S_RESP: if (rsp_ready) begin state_q <= S_IDLE; rsp_valid_q <= 1'b0; end
      default: state_q <= S_IDLE;
    endcase
endmodule

// File: tb/tb_array_memory_engine.sv
// tb_array_memory_engine: directed scenarios with hand-computed expectations for the array memory engine
module tb_array_memory_engine;
  import array_memory_pkg::*;
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [4:0] req_action = '0;
  logic [3:0] req_array = '0;
  logic [2:0] req_index = '0;
  logic [15:0] req_data = '0;
  logic req_ready, rsp_valid, rsp_error;
  logic [15:0] rsp_data;
  int errors = 0, checks = 0;
  logic [15:0] d;
  logic e;
  int l;
  array_memory_engine dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_action(req_action), .req_array(req_array), .req_index(req_index), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error)
  );
  always #5 clock = ~clock;
  task automatic do_req(input logic [4:0] a, input logic [3:0] arr, input logic [2:0] idx, input logic [15:0] dat,
                        output logic [15:0] rd, output logic re, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clock); #1; n++; end
    if (!req_ready) begin checks++; errors++; $display("FAIL req_ready_timeout got=0 exp=1"); end
    req_valid = 1'b1; req_action = a; req_array = arr; req_index = idx; req_data = dat;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    if (!rsp_valid) begin checks++; errors++; $display("FAIL rsp_valid_timeout op=%0d got=0 exp=1", a); end
    rd = rsp_data; re = rsp_error;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'd0) begin errors++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%0b exp=0", rsp_error); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask
  task automatic test_push_read;
    logic [15:0] v [3] = '{16'd5, 16'd9, 16'd3};
    for (int i = 0; i < 3; i++) begin
      do_req(A_PUSH, 4'd2, 3'd0, v[i], d, e, l);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL push_err[%0d] got=%0b exp=0", i, e); end
    end
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd3 || e !== 1'b0) begin errors++; $display("FAIL size_after_push got=%0d/%0b exp=3/0", d, e); end
    do_req(A_READ, 4'd2, 3'd1, 16'd0, d, e, l);
    checks++; if (d !== 16'd9 || e !== 1'b0) begin errors++; $display("FAIL read_2_1 got=%0d/%0b exp=9/0", d, e); end
  endtask
  task automatic test_scan;
    do_req(A_LESS, 4'd2, 3'd0, 16'd6, d, e, l);
    checks++; if (l !== 4) begin errors++; $display("FAIL less_latency got=%0d exp=4", l); end
    checks++; if (d !== 16'd2) begin errors++; $display("FAIL less_6 got=%0d exp=2", d); end
    do_req(A_INDEX, 4'd2, 3'd0, 16'd3, d, e, l);
    checks++; if (d !== 16'd3) begin errors++; $display("FAIL index_3 got=%0d exp=3", d); end
    do_req(A_INDEX, 4'd2, 3'd0, 16'd5, d, e, l);
    checks++; if (d !== 16'd1) begin errors++; $display("FAIL index_5 got=%0d exp=1", d); end
    do_req(A_INDEX, 4'd2, 3'd0, 16'd7, d, e, l);
    checks++; if (d !== 16'd0 || e !== 1'b0) begin errors++; $display("FAIL index_7 got=%0d/%0b exp=0/0", d, e); end
    do_req(A_GREATER, 4'd2, 3'd0, 16'd4, d, e, l);
    checks++; if (d !== 16'd2) begin errors++; $display("FAIL greater_4 got=%0d exp=2", d); end
    do_req(A_LESS, 4'd5, 3'd0, 16'd100, d, e, l);
    checks++; if (l !== 1 || d !== 16'd0) begin errors++; $display("FAIL empty_scan got=lat%0d/%0d exp=lat1/0", l, d); end
  endtask
  task automatic test_shift;
    logic [15:0] a4 [4] = '{16'd5, 16'd7, 16'd9, 16'd3};
    logic [15:0] a3 [3] = '{16'd7, 16'd9, 16'd3};
    do_req(A_INSERT, 4'd2, 3'd1, 16'd7, d, e, l);
    checks++; if (l !== 3 || d !== 16'd7 || e !== 1'b0) begin errors++; $display("FAIL insert got=lat%0d/%0d/%0b exp=lat3/7/0", l, d, e); end
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd4) begin errors++; $display("FAIL insert_size got=%0d exp=4", d); end
    for (int i = 0; i < 4; i++) begin
      do_req(A_READ, 4'd2, 3'(i), 16'd0, d, e, l);
      checks++; if (d !== a4[i]) begin errors++; $display("FAIL insert_word[%0d] got=%0d exp=%0d", i, d, a4[i]); end
    end
    do_req(A_DELETE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (l !== 4 || d !== 16'd5 || e !== 1'b0) begin errors++; $display("FAIL delete got=lat%0d/%0d/%0b exp=lat4/5/0", l, d, e); end
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd3) begin errors++; $display("FAIL delete_size got=%0d exp=3", d); end
    for (int i = 0; i < 3; i++) begin
      do_req(A_READ, 4'd2, 3'(i), 16'd0, d, e, l);
      checks++; if (d !== a3[i]) begin errors++; $display("FAIL delete_word[%0d] got=%0d exp=%0d", i, d, a3[i]); end
    end
    do_req(A_INSERT, 4'd2, 3'd3, 16'd11, d, e, l);
    checks++; if (l !== 1 || e !== 1'b0) begin errors++; $display("FAIL insert_append got=lat%0d/%0b exp=lat1/0", l, e); end
    do_req(A_READ, 4'd2, 3'd3, 16'd0, d, e, l);
    checks++; if (d !== 16'd11) begin errors++; $display("FAIL append_word got=%0d exp=11", d); end
    do_req(A_DELETE, 4'd2, 3'd3, 16'd0, d, e, l);
    checks++; if (l !== 1 || d !== 16'd11) begin errors++; $display("FAIL delete_last got=lat%0d/%0d exp=lat1/11", l, d); end
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd3) begin errors++; $display("FAIL delete_last_size got=%0d exp=3", d); end
  endtask
  task automatic test_full;
    for (int i = 0; i < 8; i++) do_req(A_PUSH, 4'd0, 3'd0, 16'(10 + i), d, e, l);
    do_req(A_PUSH, 4'd0, 3'd0, 16'd99, d, e, l);
    checks++; if (e !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL push_full got=%0d/%0b exp=0/1", d, e); end
    do_req(A_SIZE, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd8) begin errors++; $display("FAIL full_size got=%0d exp=8", d); end
    do_req(A_INSERT, 4'd0, 3'd0, 16'd1, d, e, l);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL insert_full got=%0b exp=1", e); end
    do_req(A_READ, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd10) begin errors++; $display("FAIL full_word0 got=%0d exp=10", d); end
    do_req(A_POP, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd17 || e !== 1'b0) begin errors++; $display("FAIL pop got=%0d/%0b exp=17/0", d, e); end
    do_req(A_SIZE, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd7) begin errors++; $display("FAIL pop_size got=%0d exp=7", d); end
    do_req(A_WRITE, 4'd4, 3'd7, 16'h55, d, e, l);
    checks++; if (d !== 16'h55 || e !== 1'b0) begin errors++; $display("FAIL write_top got=%0h/%0b exp=55/0", d, e); end
    do_req(A_SIZE, 4'd4, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd8) begin errors++; $display("FAIL write_top_size got=%0d exp=8", d); end
  endtask
  task automatic test_errors;
    do_req(A_READ, 4'd3, 3'd0, 16'd0, d, e, l);
    checks++; if (e !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL read_empty got=%0d/%0b exp=0/1", d, e); end
    do_req(A_DEC, 4'd3, 3'd0, 16'd0, d, e, l);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL dec_empty got=%0b exp=1", e); end
    do_req(A_RESIZE, 4'd3, 3'd0, 16'd9, d, e, l);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL resize_9 got=%0b exp=1", e); end
    do_req(5'd31, 4'd3, 3'd0, 16'd0, d, e, l);
    checks++; if (e !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL opcode_31 got=%0d/%0b exp=0/1", d, e); end
    do_req(A_SIZE, 4'd3, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd0 || e !== 1'b0) begin errors++; $display("FAIL error_size got=%0d/%0b exp=0/0", d, e); end
  endtask
  task automatic test_hold;
    req_valid = 1'b1; req_action = A_SIZE; req_array = 4'd2; req_index = 3'd0; req_data = 16'd0;
    @(posedge clock); #1;
    req_action = A_PUSH; req_data = 16'd77;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'd3 || req_ready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d] got=v%0b/%0d/r%0b exp=v1/3/r0", i, rsp_valid, rsp_data, req_ready);
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd3) begin errors++; $display("FAIL busy_ignored got=%0d exp=3", d); end
  endtask
  task automatic test_reset_mid;
    req_valid = 1'b1; req_action = A_INSERT; req_array = 4'd0; req_index = 3'd0; req_data = 16'd99;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_shift_busy got=%0b exp=0", req_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset got=r%0b/v%0b exp=r1/v0", req_ready, rsp_valid); end
    @(posedge clock); #1;
    reset = 1'b0;
    do_req(A_SIZE, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd0) begin errors++; $display("FAIL mid_reset_size0 got=%0d exp=0", d); end
    do_req(A_SIZE, 4'd2, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd0) begin errors++; $display("FAIL mid_reset_size2 got=%0d exp=0", d); end
  endtask
  task automatic test_clear;
    do_req(A_PUSH, 4'd1, 3'd0, 16'd42, d, e, l);
    do_req(A_SIZE, 4'd1, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd1) begin errors++; $display("FAIL pre_clear_size got=%0d exp=1", d); end
    do_req(A_CLEAR, 4'd0, 3'd0, 16'd0, d, e, l);
    checks++; if (e !== 1'b0 || d !== 16'd0) begin errors++; $display("FAIL clear got=%0d/%0b exp=0/0", d, e); end
    do_req(A_SIZE, 4'd1, 3'd0, 16'd0, d, e, l);
    checks++; if (d !== 16'd0) begin errors++; $display("FAIL post_clear_size got=%0d exp=0", d); end
  endtask
  initial begin
    test_reset();
    test_push_read();
    test_scan();
    test_shift();
    test_full();
    test_errors();
    test_hold();
    test_reset_mid();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/array_memory_engine.md
Name: array_memory_engine

Overview:
Parametrised successor to the fixed-block array memory. It holds ARRAYS independent arrays of up to DEPTH words each, with a per-array size table, and serves one request at a time over a valid/ready request and response handshake. Search and shift operations (Index, Less, Greater, Insert, Delete) run as multi-cycle state-machine sequences at one element per cycle, so they do not need wide combinational loops. It sits between the instruction decoder and array storage, and adds range checking and an error response.

Parameters:
ARRAY_BITS, 4, log2 of the array count; ARRAYS = 2**ARRAY_BITS
INDEX_BITS, 3, log2 of the array depth; DEPTH = 2**INDEX_BITS
DATA_BITS, 16, word width; must be >= INDEX_BITS+1 (elaboration-time check)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears the size table and the FSM
req_valid  in  1  request present
req_ready  out  1  engine idle; request accepted when req_valid && req_ready
req_action  in  5  opcode (see package)
req_array  in  ARRAY_BITS  target array
req_index  in  INDEX_BITS  element index
req_data  in  DATA_BITS  operand or value
rsp_valid  out  1  response present; held until rsp_ready
rsp_ready  in  1  consumer accepts the response
rsp_data  out  DATA_BITS  result
rsp_error  out  1  operation rejected; no state changed

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_error=0, state=IDLE, all sizes=0. Memory words are not reset.
- Reset mid-operation aborts immediately. Any partially shifted words stay as they are, and sizes are 0.
- FSM states: IDLE, SCAN, SHIFT_UP, SHIFT_DOWN, RESP.
- req_ready = (state==IDLE).
- On accept, request fields are latched, and size s = size[req_array] (width INDEX_BITS+1) is latched.
- IDLE: single-cycle operations execute on the accept edge and go to RESP. Multi-cycle operations go to SCAN or SHIFT_*.
- RESP: rsp_valid=1. When rsp_ready=1, go to IDLE on the next edge.
- Latency from the accept edge to the first rsp_valid cycle:
  - single-cycle operations: 1
  - SCAN: 1+s
  - Insert: 1+(s-index)
  - Delete: 1+(s-1-index)
- Throughput: at best one request every 2 cycles.
- Opcodes. All errors leave memory and sizes unchanged and set rsp_data=0.
  - Clear=1: all sizes set to 0. rsp_data=0.
  - Write=2: mem[a][i]=d. If i>=s, size becomes i+1. rsp_data=d.
  - Read=3: rsp_data=mem[a][i]. Error if i>=s.
  - Size=4: rsp_data=s.
  - Inc=5: size+1. Error if s==DEPTH.
  - Dec=6: size-1. Error if s==0.
  - Index=7: SCAN over 0..s-1. rsp_data = lowest matching index+1, or 0 if no element equals d.
  - Less=8 / Greater=9: SCAN over 0..s-1. rsp_data = count of elements < d / > d, unsigned compare.
  - Insert=10: error if s==DEPTH or i>s. SHIFT_UP copies j-1 to j for j = s down to i+1, one per cycle. Then mem[a][i]=d and size becomes s+1; this write happens on the transition to RESP. rsp_data=d.
  - Delete=11: error if i>=s. rsp_data = old mem[a][i]. SHIFT_DOWN copies j+1 to j for j = i to s-2. Size becomes s-1.
  - Push=14: mem[a][s]=d and size becomes s+1. Error if s==DEPTH.
  - Pop=15: size becomes s-1 and rsp_data=mem[a][s-1]. Error if s==0.
  - Resize=17: size becomes d. Error if d>DEPTH.
  - Any other opcode: error.
- Boundaries:
  - Insert at i==s appends, with zero shift cycles.
  - Delete of the last element takes zero shift cycles.
  - Index, Less and Greater on an empty array respond after 1 cycle with 0.
  - Write to index DEPTH-1 sets size to DEPTH.
- req_* is ignored while busy; there is no queue.

Decomposition:
- array_memory_pkg: action_t enum (opcodes above), state_t enum, and DEPTH/ARRAYS localparam helper functions.
- One sub-module, array_memory_store. It holds the flat word array addressed {array,index} (1 write port, 2 combinational read ports) and the size table with async clear.
- The engine FSM, shift/scan counters and response register live in array_memory_engine.

Test Plan:
- Reset, then Push 5, 9, 3 to array 2, then Size(2): rsp_data=3, rsp_error=0. Read(2,1) returns 9.
- Less(2,d=6): rsp_valid 4 cycles after accept, rsp_data=2. Index(2,d=3) returns 3. Index(2,d=7) returns 0.
- Insert(2,i=1,d=7) on [5,9,3]: latency 3; array becomes [5,7,9,3], size 4. Then Delete(2,i=0): rsp_data=5; array becomes [7,9,3].
- Fill array 0 to DEPTH=8 with Push, then Push again: rsp_error=1, size stays 8. Insert also errors. Pop returns the last value and gives size 7.
- Read(3,0) on an empty array, Dec on an empty array, Resize d=9, and opcode 31: all return rsp_error=1 with no state change.
- Start Insert on an 8-deep array (s=7, i=0), assert reset during SHIFT_UP: state IDLE, rsp_valid=0, Size(any)=0. Also hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stay stable and req_ready stays 0.
